// File: rtl/uart_apb4_bridge.sv
// uart_apb4_bridge: turns a UART byte stream of fixed R/W frames into single
// APB4 master transfers and streams back a status/data reply.
// Optional feature: define UART_APB4_BRIDGE_TIMEOUT_EN to abort ACCESS phases
// that see no pready within APB_TIMEOUT cycles (reply 'T').
module uart_apb4_bridge #(
  parameter int ADDR_WIDTH    = 32,
  parameter int FRAME_TIMEOUT = 100000,
  parameter int APB_TIMEOUT   = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [2:0]            pprot_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [31:0]           pwdata_o,
  output logic [3:0]            pstrb_o,
  input  logic [31:0]           prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] RSP_OK     = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h45;
  localparam logic [7:0] RSP_BADOP  = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_RSP
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [7:0]     status_q, status_d;
  logic           pwrite_q, pwrite_d;
  logic [2:0]     rsp_idx_q, rsp_idx_d;
  logic [2:0]     rsp_last_q, rsp_last_d;
  logic [FT_W-1:0] ftmr_q, ftmr_d;

`ifdef UART_APB4_BRIDGE_TIMEOUT_EN
  localparam int AT_W = $clog2(APB_TIMEOUT + 1);
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;
  logic [AT_W-1:0] atmr_q, atmr_d;
`else
  // ACCESS waits forever in this build, so the APB timeout value has no use
  logic unused_apb_timeout;
  assign unused_apb_timeout = (APB_TIMEOUT != 0);
`endif

  logic rx_fire;
  logic tx_fire;

  assign rx_fire = rx_valid_i & rx_ready_o;
  assign tx_fire = tx_valid_o & tx_ready_i;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
      pwrite_q   <= 1'b0;
      rsp_idx_q  <= '0;
      rsp_last_q <= '0;
      ftmr_q     <= '0;
`ifdef UART_APB4_BRIDGE_TIMEOUT_EN
      atmr_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      pwrite_q   <= pwrite_d;
      rsp_idx_q  <= rsp_idx_d;
      rsp_last_q <= rsp_last_d;
      ftmr_q     <= ftmr_d;
`ifdef UART_APB4_BRIDGE_TIMEOUT_EN
      atmr_q     <= atmr_d;
`endif
    end
  end

  // Next-state logic: frame parsing, bus sequencing and reply indexing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    pwrite_d   = pwrite_q;
    rsp_idx_d  = rsp_idx_q;
    rsp_last_d = rsp_last_q;
    ftmr_d     = ftmr_q;
`ifdef UART_APB4_BRIDGE_TIMEOUT_EN
    atmr_d     = atmr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        ftmr_d = '0;
        if (rx_fire) begin
          cnt_d = '0;
          if (rx_data_i == OP_WRITE) begin
            pwrite_d = 1'b1;
            state_d  = ST_ADDR;
          end else if (rx_data_i == OP_READ) begin
            pwrite_d = 1'b0;
            state_d  = ST_ADDR;
          end else begin
            status_d   = RSP_BADOP;
            rsp_idx_d  = '0;
            rsp_last_d = '0;
            state_d    = ST_RSP;
          end
        end
      end
      ST_ADDR, ST_WDATA: begin
        if (rx_fire) begin
          ftmr_d = '0;
          cnt_d  = cnt_q + 3'd1;
          if (state_q == ST_ADDR) begin
            addr_d = {rx_data_i, addr_q[31:8]};
          end else begin
            wdata_d = {rx_data_i, wdata_q[31:8]};
          end
          if (cnt_q == 3'd3) begin
            cnt_d = '0;
            if (state_q == ST_ADDR && pwrite_q) begin
              state_d = ST_WDATA;
            end else begin
              state_d = ST_SETUP;
            end
          end
        end else if (ftmr_q == FT_W'(FRAME_TIMEOUT - 1)) begin
          ftmr_d  = '0;
          state_d = ST_IDLE;
        end else begin
          ftmr_d = ftmr_q + FT_W'(1);
        end
      end
      ST_SETUP: begin
`ifdef UART_APB4_BRIDGE_TIMEOUT_EN
        atmr_d = '0;
`endif
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          rdata_d    = prdata_i;
          status_d   = pslverr_i ? RSP_ERR : RSP_OK;
          rsp_idx_d  = '0;
          rsp_last_d = pwrite_q ? 3'd0 : 3'd4;
          state_d    = ST_RSP;
        end
`ifdef UART_APB4_BRIDGE_TIMEOUT_EN
        else if (atmr_q == AT_W'(APB_TIMEOUT - 1)) begin
          rdata_d    = '0;
          status_d   = RSP_TIMEOUT;
          rsp_idx_d  = '0;
          rsp_last_d = pwrite_q ? 3'd0 : 3'd4;
          state_d    = ST_RSP;
        end else begin
          atmr_d = atmr_q + AT_W'(1);
        end
`endif
      end
      ST_RSP: begin
        if (tx_fire) begin
          if (rsp_idx_q == rsp_last_q) begin
            rsp_idx_d = '0;
            state_d   = ST_IDLE;
          end else begin
            rsp_idx_d = rsp_idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; select/ready are masked during reset so the bus drops at once
  always_comb begin
    rx_ready_o = ~rst_i & ((state_q == ST_IDLE) | (state_q == ST_ADDR) |
                           (state_q == ST_WDATA));
    psel_o     = ~rst_i & ((state_q == ST_SETUP) | (state_q == ST_ACCESS));
    penable_o  = ~rst_i & (state_q == ST_ACCESS);
    tx_valid_o = (state_q == ST_RSP);
    tx_data_o  = 8'h00;
    if (state_q == ST_RSP) begin
      unique case (rsp_idx_q)
        3'd0:    tx_data_o = status_q;
        3'd1:    tx_data_o = rdata_q[7:0];
        3'd2:    tx_data_o = rdata_q[15:8];
        3'd3:    tx_data_o = rdata_q[23:16];
        3'd4:    tx_data_o = rdata_q[31:24];
        default: tx_data_o = 8'h00;
      endcase
    end
    paddr_o  = ADDR_WIDTH'(addr_q);
    pprot_o  = 3'b000;
    pwrite_o = pwrite_q;
    pwdata_o = wdata_q;
    pstrb_o  = pwrite_q ? 4'hF : 4'h0;
  end

endmodule
